// File: rtl/sa_skew_feeder.sv
// Buffers a 3x3 window and kernel, then streams them skewed into a 2x2 systolic
// array as a true convolution (pixel A[i] paired with K[8-i]).
module sa_skew_feeder #(
  parameter int DW    = 8,
  parameter int DRAIN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] pix_in,
  input  logic [DW-1:0] ker_in,
  output logic [DW-1:0] din0,
  output logic [DW-1:0] din1,
  output logic [DW-1:0] win0,
  output logic [DW-1:0] win1,
  output logic          sa_clear,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [3:0] DRAIN_LAST = (DRAIN == 0) ? 4'd0 : 4'(DRAIN - 1);

  state_t        state_reg;
  logic [3:0]    idx_reg;
  logic [2:0]    step_reg;
  logic [3:0]    drain_reg;
  logic [DW-1:0] a_mem [9];
  logic [DW-1:0] k_mem [9];

  logic [2:0]    step_next;
  logic [DW-1:0] din0_next;
  logic [DW-1:0] din1_next;
  logic [DW-1:0] win0_next;
  logic [DW-1:0] win1_next;
  logic          accept;

  assign accept    = ld_valid && ld_ready && (state_reg == ST_LOAD);
  assign step_next = (state_reg == ST_CLEAR) ? 3'd0 : step_reg + 3'd1;

  // Stream values for the step about to be presented; lane 1 idles on step 0.
  always_comb begin
    din0_next = '0;
    din1_next = '0;
    win0_next = '0;
    win1_next = '0;
    case (step_next)
      3'd0: begin
        din0_next = a_mem[0]; win0_next = k_mem[8];
      end
      3'd1: begin
        din0_next = a_mem[1]; win0_next = k_mem[7];
        din1_next = a_mem[3]; win1_next = k_mem[5];
      end
      3'd2: begin
        din0_next = a_mem[2]; win0_next = k_mem[6];
        din1_next = a_mem[4]; win1_next = k_mem[4];
      end
      3'd3: begin
        din0_next = a_mem[6]; win0_next = k_mem[2];
        din1_next = a_mem[5]; win1_next = k_mem[3];
      end
      3'd4: begin
        din0_next = a_mem[8]; win0_next = k_mem[0];
        din1_next = a_mem[7]; win1_next = k_mem[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_LOAD;
      idx_reg   <= '0;
      step_reg  <= '0;
      drain_reg <= '0;
      for (int i = 0; i < 9; i++) begin
        a_mem[i] <= '0;
        k_mem[i] <= '0;
      end
      ld_ready  <= 1'b1;
      sa_clear  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      din0      <= '0;
      din1      <= '0;
      win0      <= '0;
      win1      <= '0;
    end else begin
      // Pulses and streams default low; only STREAM steps load real data.
      sa_clear <= 1'b0;
      done     <= 1'b0;
      din0     <= '0;
      din1     <= '0;
      win0     <= '0;
      win1     <= '0;
      case (state_reg)
        ST_LOAD: begin
          if (accept) begin
            a_mem[idx_reg] <= pix_in;
            k_mem[idx_reg] <= ker_in;
            if (idx_reg == 4'd8) begin
              state_reg <= ST_CLEAR;
              idx_reg   <= '0;
              ld_ready  <= 1'b0;
              busy      <= 1'b1;
              sa_clear  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end
        end
        ST_CLEAR: begin
          state_reg <= ST_STREAM;
          step_reg  <= step_next;
          din0      <= din0_next;
          din1      <= din1_next;
          win0      <= win0_next;
          win1      <= win1_next;
        end
        ST_STREAM: begin
          if (step_reg == 3'd4) begin
            if (DRAIN == 0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_DRAIN;
              drain_reg <= '0;
            end
          end else begin
            step_reg <= step_next;
            din0     <= din0_next;
            din1     <= din1_next;
            win0     <= win0_next;
            win1     <= win1_next;
          end
        end
        ST_DRAIN: begin
          if (drain_reg == DRAIN_LAST) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end else begin
            drain_reg <= drain_reg + 4'd1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_LOAD;
          idx_reg   <= '0;
          busy      <= 1'b0;
          ld_ready  <= 1'b1;
        end
        default: begin
          state_reg <= ST_LOAD;
          idx_reg   <= '0;
          busy      <= 1'b0;
          ld_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: literal vector table for the nominal window plus
// randomized windows checked cycle by cycle against a convolution-order model.
module tb_sa_skew_feeder;
  localparam int DW        = 8;
  localparam int DRAIN     = 2;
  localparam int DONE_CYC  = 7 + DRAIN;
  localparam int LAST_CYC  = 8 + DRAIN;

  typedef int win_t [9];
  typedef int obs_t [5][4];
  typedef struct {
    int pix;
    int ker;
    int d0;
    int d1;
    int w0;
    int w1;
  } nom_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic [DW-1:0] ker_in = '0;
  logic          ld_ready, sa_clear, busy, done;
  logic [DW-1:0] din0, din1, win0, win1;

  int   checks = 0;
  int   errors = 0;
  int   cur_cyc = 0;
  int   lane0_idx [5];
  int   lane1_idx [5];
  nom_t nom_tab [9];

  always #5 clk = ~clk;

  sa_skew_feeder #(.DW(DW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .pix_in(pix_in), .ker_in(ker_in), .din0(din0), .din1(din1),
    .win0(win0), .win1(win1), .sa_clear(sa_clear), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc%0d: got %0d expected %0d", name, cur_cyc, act, exp);
    end
  endtask

  // Convolution pairing: lane order from the skew schedule, weight is K[8-i].
  function automatic void model_step(input win_t a, input win_t k, input int s,
                                     output int d0, output int d1,
                                     output int w0, output int w1);
    d0 = a[lane0_idx[s]];
    w0 = k[8 - lane0_idx[s]];
    if (lane1_idx[s] < 0) begin
      d1 = 0;
      w1 = 0;
    end else begin
      d1 = a[lane1_idx[s]];
      w1 = k[8 - lane1_idx[s]];
    end
  endfunction

  task automatic check_idle_after_reset();
    chk("rst_din0", din0, 0);
    chk("rst_din1", din1, 0);
    chk("rst_win0", win0, 0);
    chk("rst_win1", win1, 0);
    chk("rst_sa_clear", sa_clear, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
  endtask

  task automatic load_window(input win_t a, input win_t k, input bit gapped);
    int  idx = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    bit  acc;
    while (idx < 9 && cyc < 60) begin
      chk("ld_ready_load", ld_ready, 1);
      ld_valid = gapped ? tog : 1'b1;
      pix_in   = ld_valid ? DW'(a[idx]) : DW'($urandom);
      ker_in   = ld_valid ? DW'(k[idx]) : DW'($urandom);
      acc      = ld_valid && ld_ready;
      tick();
      if (acc) idx++;
      tog = ~tog;
      cyc++;
    end
    if (idx < 9) chk("load_timeout", idx, 9);
    ld_valid = 1'b0;
  endtask

  task automatic run_window(input string tag, input win_t a, input win_t k,
                            input bit gapped, input bit busy_beats,
                            input int abort_cyc, output obs_t obs, output int prod);
    int d0, d1, w0, w1, s;
    prod = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4; j++) obs[i][j] = -1;
    load_window(a, k, gapped);
    for (int c = 1; c <= LAST_CYC; c++) begin
      cur_cyc = c;
      s = c - 2;
      d0 = 0; d1 = 0; w0 = 0; w1 = 0;
      if (s >= 0 && s <= 4) model_step(a, k, s, d0, d1, w0, w1);
      chk("sa_clear", sa_clear, int'(c == 1));
      chk("done", done, int'(c == DONE_CYC));
      chk("busy", busy, int'(c <= DONE_CYC));
      chk("ld_ready", ld_ready, int'(c == LAST_CYC));
      chk("din0", din0, d0);
      chk("din1", din1, d1);
      chk("win0", win0, w0);
      chk("win1", win1, w1);
      if (s >= 0 && s <= 4) begin
        obs[s][0] = din0; obs[s][1] = din1; obs[s][2] = win0; obs[s][3] = win1;
        prod += int'(din0) * int'(win0) + int'(din1) * int'(win1);
      end
      if (c == abort_cyc) begin
        rst = 1'b0;
        ld_valid = 1'b0;
        tick();
        cur_cyc = c + 1;
        check_idle_after_reset();
        rst = 1'b1;
        break;
      end
      if (c < LAST_CYC) begin
        ld_valid = busy_beats && (c < DONE_CYC);
        pix_in   = '1;
        ker_in   = '1;
        tick();
      end
    end
    ld_valid = 1'b0;
    $display("run %s: gapped=%0d busy_beats=%0d abort=%0d products=%0d",
             tag, gapped, busy_beats, abort_cyc, prod);
  endtask

  task automatic compare_tab(input string tag, input obs_t obs);
    for (int s = 0; s < 5; s++) begin
      cur_cyc = s + 2;
      chk({tag, "_din0"}, obs[s][0], nom_tab[s].d0);
      chk({tag, "_din1"}, obs[s][1], nom_tab[s].d1);
      chk({tag, "_win0"}, obs[s][2], nom_tab[s].w0);
      chk({tag, "_win1"}, obs[s][3], nom_tab[s].w1);
    end
  endtask

  initial begin
    win_t a, k, nom_a, nom_k;
    obs_t obs;
    int   prod;
    int   ker_list [9];

    lane0_idx = '{0, 1, 2, 6, 8};
    lane1_idx = '{-1, 3, 4, 5, 7};
    ker_list  = '{0, 9, 8, 1, 2, 3, 7, 8, 9};
    for (int i = 0; i < 9; i++) begin
      nom_tab[i] = '{pix: i + 1, ker: ker_list[i], d0: 0, d1: 0, w0: 0, w1: 0};
    end
    nom_tab[0].d0 = 1; nom_tab[0].d1 = 0; nom_tab[0].w0 = 9; nom_tab[0].w1 = 0;
    nom_tab[1].d0 = 2; nom_tab[1].d1 = 4; nom_tab[1].w0 = 8; nom_tab[1].w1 = 3;
    nom_tab[2].d0 = 3; nom_tab[2].d1 = 5; nom_tab[2].w0 = 7; nom_tab[2].w1 = 2;
    nom_tab[3].d0 = 7; nom_tab[3].d1 = 6; nom_tab[3].w0 = 8; nom_tab[3].w1 = 1;
    nom_tab[4].d0 = 9; nom_tab[4].d1 = 8; nom_tab[4].w0 = 0; nom_tab[4].w1 = 9;
    for (int i = 0; i < 9; i++) begin
      nom_a[i] = nom_tab[i].pix;
      nom_k[i] = nom_tab[i].ker;
    end

    // Reset held for one edge.
    rst = 1'b0;
    tick();
    check_idle_after_reset();
    $display("reset: idle state observed");
    rst = 1'b1;

    run_window("nominal", nom_a, nom_k, 1'b0, 1'b0, 0, obs, prod);
    compare_tab("nom", obs);
    chk("nom_array_sum", prod, 202);

    run_window("gapped", nom_a, nom_k, 1'b1, 1'b0, 0, obs, prod);
    compare_tab("gap", obs);

    for (int i = 0; i < 9; i++) begin
      a[i] = $urandom_range(0, 255);
      k[i] = $urandom_range(0, 255);
    end
    run_window("abort_step2", a, k, 1'b0, 1'b0, 4, obs, prod);
    for (int i = 0; i < 9; i++) begin
      a[i] = 5;
      k[i] = 3;
    end
    run_window("fresh_5_3", a, k, 1'b0, 1'b0, 0, obs, prod);

    run_window("busy_beats", nom_a, nom_k, 1'b0, 1'b1, 0, obs, prod);
    compare_tab("busy", obs);
    run_window("after_busy", nom_a, nom_k, 1'b0, 1'b0, 0, obs, prod);
    compare_tab("after", obs);

    for (int i = 0; i < 9; i++) begin
      a[i] = 255;
      k[i] = 255;
    end
    run_window("max_b2b", a, k, 1'b0, 1'b0, 0, obs, prod);
    chk("max_bubble_din1", obs[0][1], 0);
    chk("max_bubble_win1", obs[0][3], 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 9; i++) begin
        a[i] = $urandom_range(0, 255);
        k[i] = $urandom_range(0, 255);
      end
      run_window($sformatf("random%0d", r), a, k, 1'($urandom_range(0, 1)), 1'b0, 0, obs, prod);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_skew_feeder.md
SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

Interface
REQ-001 Parameter DW, default 8, sets the data width of pixel, kernel and stream ports.
REQ-002 Parameter DRAIN, default 2, sets the zero-input cycles after streaming so the array can settle; legal range 0..15.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; it is sampled on the rising edge of clk.
REQ-005 ld_valid  input  1  a pixel/kernel beat is presented.
REQ-006 ld_ready  output  1  the feeder accepts a beat this cycle.
REQ-007 pix_in  input  DW  window pixel A[i], row-major, i=0..8.
REQ-008 ker_in  input  DW  kernel coefficient K[i], row-major, i=0..8.
REQ-009 din0, din1  output  DW each  activation streams to the 2x2 array lanes 0 and 1.
REQ-010 win0, win1  output  DW each  weight streams to the 2x2 array lanes 0 and 1.
REQ-011 sa_clear  output  1  one-cycle accumulator clear to the array.
REQ-012 busy  output  1  high from the CLEAR state through the DONE state.
REQ-013 done  output  1  one-cycle pulse; the array output is valid in this cycle.

Function
REQ-014 The feeder SHALL have states LOAD, CLEAR, STREAM, DRAIN and DONE; all outputs SHALL be registered.
REQ-015 LOAD: ld_ready=1 and a 4-bit index increments on each ld_valid&&ld_ready edge, storing pix_in to A[idx] and ker_in to K[idx].
REQ-016 When the feeder accepts beat idx=8, it SHALL go to CLEAR on the same edge; ld_ready=0 in every state except LOAD.
REQ-017 In LOAD, cycles with ld_valid low SHALL NOT advance idx; beats offered outside LOAD SHALL be ignored.
REQ-018 CLEAR lasts 1 cycle: sa_clear=1, all stream outputs 0, then the feeder goes to STREAM.
REQ-019 STREAM lasts exactly 5 cycles, step s=0..4; the feeder computes true convolution, so the weight paired with A[i] is K[8-i].
REQ-020 Lane 0 pixel order SHALL be A[0],A[1],A[2],A[6],A[8] on steps 0..4.
REQ-021 Lane 1 pixel order SHALL be 0 (bubble),A[3],A[4],A[5],A[7] on steps 0..4.
REQ-022 win0/win1 SHALL carry K[8-i] for the pixel A[i] on the same lane in the same cycle; in the lane-1 bubble cycle, win1=0.
REQ-023 DRAIN: all streams 0 for DRAIN cycles; with DRAIN=0 the feeder goes directly from STREAM to DONE.
REQ-024 DONE lasts 1 cycle: done=1, streams 0, then the feeder goes to LOAD with idx=0; buffer contents are retained but overwritten by the next load.
REQ-025 In every non-STREAM cycle, din0/din1/win0/win1 SHALL be 0.
REQ-026 Values SHALL pass through unmodified (no arithmetic); the full DW-bit range 0..2^DW-1 is legal.
REQ-027 Latency from the accept edge of beat 8 is: sa_clear in the next cycle, step 0 in the cycle after that, and done in cycle 7+DRAIN.

Reset
REQ-028 While rst=0 at a clock edge, the feeder SHALL go to LOAD with idx=0, and all of din0,din1,win0,win1,sa_clear,done,busy SHALL be 0; ld_ready=1 from the next cycle.
REQ-029 A reset in any state, including mid-STREAM or mid-LOAD, SHALL abort the operation; beats already accepted are discarded, and A/K are cleared to 0.

Verification
REQ-030 Reset: hold rst=0 for 1 edge -> all outputs 0, ld_ready=1, busy=0.
REQ-031 Nominal run: load A=1..9 and K=0,9,8,1,2,3,7,8,9, then check the following.
  - sa_clear pulses once.
  - (din0,din1,win0,win1) over the 5 STREAM cycles = (1,0,9,0),(2,4,8,3),(3,5,7,2),(7,6,8,1),(9,8,0,9), then all zeros.
  - done pulses on cycle 9 after the last accept (DRAIN=2).
  - With sa2x2 attached, the array output is 202.
REQ-032 Gapped load: deassert ld_valid on alternate cycles while loading 9 beats -> only accepted beats count, and the stream is identical to REQ-031.
REQ-033 Reset mid-stream: assert rst=0 at step 2 -> next cycle all outputs 0, ld_ready=1; a subsequent fresh load of all-5 pixels and all-3 kernel streams 5/3 on every non-bubble slot.
REQ-034 Busy-time beats: hold ld_valid=1 with pix_in=255 during STREAM/DRAIN -> ld_ready=0, the stream is unchanged, and the first beat accepted after done is A[0].
REQ-035 Back-to-back runs with max values: a second window of all 255 is loaded immediately after done -> streams carry 255 on every non-bubble slot, and the lane-1 step-0 slot is 0.
